// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Hazard and forwarding controller for a five-stage pipeline (IF, DEC, EX,
//   MEM, WB). It drives the EX operand forwarding muxes, the per-stage hold and
//   bubble controls, and the taken-branch flush. It also keeps a saturating
//   count of stalled cycles.
//
// Parameters
//   NUM_SRC   number of EX source operands checked (1..3)
//   LOAD_LAT  cycles from a load entering MEM until its data is forwardable (1..8)
//   STAT_W    width of the stall statistics counter
//
// Ports
//   CLK, RST                  clock and synchronous active-high reset
//   ex_rs_addr/ex_rs_used     EX source addresses (5 bits each) and their use flags
//   mem_rd_addr/mem_reg_write/mem_is_load   MEM-stage destination info
//   wb_rd_addr/wb_reg_write   WB-stage destination info
//   ex_br_taken               EX holds a taken branch or jump
//   ext_stall_req             a multi-cycle EX unit is busy
//   fwd_sel                   per-source forward select (00 RF, 01 MEM, 10 WB)
//   hold_*, bubble_*, *_flush pipeline control
//   stall_cycles              saturating count of cycles with hold_if=1

module pipeline_hazard_ctrl #(
    parameter int NUM_SRC  = 2,
    parameter int LOAD_LAT = 1,
    parameter int STAT_W   = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [5*NUM_SRC-1:0] ex_rs_addr,
    input  logic [NUM_SRC-1:0]   ex_rs_used,
    input  logic [4:0]           mem_rd_addr,
    input  logic                 mem_reg_write,
    input  logic                 mem_is_load,
    input  logic [4:0]           wb_rd_addr,
    input  logic                 wb_reg_write,
    input  logic                 ex_br_taken,
    input  logic                 ext_stall_req,
    output logic [2*NUM_SRC-1:0] fwd_sel,
    output logic                 hold_if,
    output logic                 hold_dec,
    output logic                 hold_ex,
    output logic                 hold_mem,
    output logic                 bubble_mem,
    output logic                 bubble_wb,
    output logic                 if_flush,
    output logic                 dec_flush,
    output logic [STAT_W-1:0]    stall_cycles
);

    // A one-cycle latency still needs a one-bit counter so the ports stay legal.
    localparam int CNT_W = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;

    logic [CNT_W-1:0] cnt;
    logic             load_wait;
    logic             load_match;
    logic             load_use;

    generate
        if (LOAD_LAT > 1) begin : g_wait
            localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOAD_LAT - 1);
            assign load_wait = mem_is_load && (cnt < CNT_LAST);
        end else begin : g_no_wait
            assign load_wait = 1'b0;
        end
    endgenerate

    // Forwarding. x0 and unused sources never forward. A load in MEM cannot
    // forward yet, so its match selects the register file and triggers load-use.
    always_comb begin
        fwd_sel    = '0;
        load_match = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (ex_rs_used[i] && (ex_rs_addr[5*i +: 5] != 5'd0)) begin
                if (mem_is_load && (ex_rs_addr[5*i +: 5] == mem_rd_addr)) begin
                    load_match = 1'b1;
                end
                if (mem_reg_write && (ex_rs_addr[5*i +: 5] == mem_rd_addr)) begin
                    fwd_sel[2*i +: 2] = mem_is_load ? 2'b00 : 2'b01;
                end else if (wb_reg_write && (ex_rs_addr[5*i +: 5] == wb_rd_addr)) begin
                    fwd_sel[2*i +: 2] = 2'b10;
                end
            end
        end
        if (RST) begin
            fwd_sel = '0;
        end
    end

    assign load_use = mem_is_load && !load_wait && load_match;

    // Priority: external stall > load not ready > load-use > branch flush.
    // The flush is taken from hold_ex so a branch held in EX is re-evaluated
    // on release rather than flushing younger work early.
    always_comb begin
        hold_if    = 1'b0;
        hold_dec   = 1'b0;
        hold_ex    = 1'b0;
        hold_mem   = 1'b0;
        bubble_mem = 1'b0;
        bubble_wb  = 1'b0;
        if_flush   = 1'b0;
        dec_flush  = 1'b0;
        if (!RST) begin
            if (ext_stall_req || load_wait) begin
                hold_if   = 1'b1;
                hold_dec  = 1'b1;
                hold_ex   = 1'b1;
                hold_mem  = 1'b1;
                bubble_wb = 1'b1;
            end else if (load_use) begin
                hold_if    = 1'b1;
                hold_dec   = 1'b1;
                hold_ex    = 1'b1;
                bubble_mem = 1'b1;
            end
            if (ex_br_taken && !hold_ex) begin
                if_flush  = 1'b1;
                dec_flush = 1'b1;
            end
        end
    end

    // The latency counter keeps running under an external stall because the
    // memory access proceeds in wall-clock time; it clears whenever MEM moves.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt          <= '0;
            stall_cycles <= '0;
        end else begin
            if (!hold_mem) begin
                cnt <= '0;
            end else if (load_wait) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (hold_if && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + STAT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic [9:0]  rs_addr;
    logic [1:0]  rs_used;
    logic [4:0]  mem_rd;
    logic        mem_rw;
    logic        mem_ld;
    logic [4:0]  wb_rd;
    logic        wb_rw;
    logic        br;
    logic        ext;

    // ctl = {hold_if, hold_dec, hold_ex, hold_mem, bubble_mem, bubble_wb, if_flush, dec_flush}
    logic [3:0]  fwd0, fwd1, fwd2;
    logic [7:0]  ctl0, ctl1, ctl2;
    logic [15:0] stat0, stat1;
    logic [1:0]  stat2;

    int passed = 0;
    int total  = 0;

    always #5 CLK = ~CLK;

    pipeline_hazard_ctrl #(.NUM_SRC(2), .LOAD_LAT(1), .STAT_W(16)) u_l1 (
        .CLK(CLK), .RST(RST), .ex_rs_addr(rs_addr), .ex_rs_used(rs_used),
        .mem_rd_addr(mem_rd), .mem_reg_write(mem_rw), .mem_is_load(mem_ld),
        .wb_rd_addr(wb_rd), .wb_reg_write(wb_rw), .ex_br_taken(br), .ext_stall_req(ext),
        .fwd_sel(fwd0), .hold_if(ctl0[7]), .hold_dec(ctl0[6]), .hold_ex(ctl0[5]),
        .hold_mem(ctl0[4]), .bubble_mem(ctl0[3]), .bubble_wb(ctl0[2]),
        .if_flush(ctl0[1]), .dec_flush(ctl0[0]), .stall_cycles(stat0));

    pipeline_hazard_ctrl #(.NUM_SRC(2), .LOAD_LAT(3), .STAT_W(16)) u_l3 (
        .CLK(CLK), .RST(RST), .ex_rs_addr(rs_addr), .ex_rs_used(rs_used),
        .mem_rd_addr(mem_rd), .mem_reg_write(mem_rw), .mem_is_load(mem_ld),
        .wb_rd_addr(wb_rd), .wb_reg_write(wb_rw), .ex_br_taken(br), .ext_stall_req(ext),
        .fwd_sel(fwd1), .hold_if(ctl1[7]), .hold_dec(ctl1[6]), .hold_ex(ctl1[5]),
        .hold_mem(ctl1[4]), .bubble_mem(ctl1[3]), .bubble_wb(ctl1[2]),
        .if_flush(ctl1[1]), .dec_flush(ctl1[0]), .stall_cycles(stat1));

    pipeline_hazard_ctrl #(.NUM_SRC(2), .LOAD_LAT(4), .STAT_W(2)) u_l4 (
        .CLK(CLK), .RST(RST), .ex_rs_addr(rs_addr), .ex_rs_used(rs_used),
        .mem_rd_addr(mem_rd), .mem_reg_write(mem_rw), .mem_is_load(mem_ld),
        .wb_rd_addr(wb_rd), .wb_reg_write(wb_rw), .ex_br_taken(br), .ext_stall_req(ext),
        .fwd_sel(fwd2), .hold_if(ctl2[7]), .hold_dec(ctl2[6]), .hold_ex(ctl2[5]),
        .hold_mem(ctl2[4]), .bubble_mem(ctl2[3]), .bubble_wb(ctl2[2]),
        .if_flush(ctl2[1]), .dec_flush(ctl2[0]), .stall_cycles(stat2));

    // Reference model state per instance: how long the load in MEM has been
    // waiting, and the stall statistic (-1 until the first reset edge).
    int lat [3] = '{1, 3, 4};
    int smax[3] = '{65535, 65535, 3};
    int age [3] = '{0, 0, 0};
    int stat[3] = '{-1, -1, -1};
    logic [3:0] exp_fwd[3];
    logic [7:0] exp_ctl[3];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want)
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        else
            passed++;
    endtask

    function automatic void model_out(input int l, input int a,
                                      output logic [3:0] f, output logic [7:0] c);
        logic [4:0] s;
        logic       waiting, dep;
        f = '0; c = '0; dep = 1'b0;
        if (RST) return;
        for (int i = 0; i < 2; i++) begin
            s = rs_addr[5*i +: 5];
            if (rs_used[i] && s != 0) begin
                if (mem_ld && s == mem_rd) dep = 1'b1;
                if (mem_rw && s == mem_rd) f[2*i +: 2] = mem_ld ? 2'd0 : 2'd1;
                else if (wb_rw && s == wb_rd) f[2*i +: 2] = 2'd2;
            end
        end
        waiting = mem_ld && (a < l - 1);
        if (ext || waiting)  c = 8'b1111_0100;
        else if (mem_ld && dep) c = 8'b1110_1000;
        if (br && !c[5]) c[1:0] = 2'b11;
    endfunction

    function automatic logic [3:0] dut_fwd(input int k);
        return (k == 0) ? fwd0 : (k == 1) ? fwd1 : fwd2;
    endfunction
    function automatic logic [7:0] dut_ctl(input int k);
        return (k == 0) ? ctl0 : (k == 1) ? ctl1 : ctl2;
    endfunction
    function automatic logic [15:0] dut_stat(input int k);
        return (k == 0) ? stat0 : (k == 1) ? stat1 : {14'd0, stat2};
    endfunction

    task automatic eval_cycle();
        #1;
        for (int k = 0; k < 3; k++) begin
            model_out(lat[k], age[k], exp_fwd[k], exp_ctl[k]);
            chk($sformatf("fwd_u%0d", k), 32'(dut_fwd(k)), 32'(exp_fwd[k]));
            chk($sformatf("ctl_u%0d", k), 32'(dut_ctl(k)), 32'(exp_ctl[k]));
            if (stat[k] >= 0)
                chk($sformatf("stat_u%0d", k), 32'(dut_stat(k)), 32'(stat[k]));
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        for (int k = 0; k < 3; k++) begin
            if (RST) begin
                age[k]  = 0;
                stat[k] = 0;
            end else begin
                if (!exp_ctl[k][4]) age[k] = 0;
                else if (mem_ld && age[k] < lat[k] - 1) age[k]++;
                if (exp_ctl[k][7] && stat[k] < smax[k]) stat[k]++;
            end
        end
    endtask

    task automatic idle();
        rs_addr = '0; rs_used = '0; mem_rd = '0; mem_rw = 0; mem_ld = 0;
        wb_rd = '0; wb_rw = 0; br = 0; ext = 0;
    endtask

    task automatic do_reset();
        idle();
        RST = 1; eval_cycle(); tick();
        RST = 0;
    endtask

    initial begin
        idle();
        RST = 1;
        eval_cycle(); tick();
        eval_cycle(); tick();
        RST = 0;

        // x0 never forwards
        rs_addr = '0; rs_used = 2'b11; mem_rd = 0; mem_rw = 1; wb_rd = 0; wb_rw = 1;
        eval_cycle();
        chk("x0_fwd", 32'(fwd0), 0);
        chk("x0_hold", 32'(ctl0[7]), 0);
        tick();

        // ALU forwarding from MEM, then WB
        rs_addr = {5'd5, 5'd5}; mem_rd = 5; mem_rw = 1; wb_rd = 5; wb_rw = 1;
        eval_cycle(); chk("alu_mem_fwd", 32'(fwd0), 32'b0101); tick();
        mem_rw = 0;
        eval_cycle(); chk("alu_wb_fwd", 32'(fwd0), 32'b1010); tick();

        // Load-use with LOAD_LAT=1
        do_reset();
        rs_addr = {5'd7, 5'd3}; rs_used = 2'b11; mem_rd = 7; mem_rw = 1; mem_ld = 1;
        eval_cycle(); chk("lu_ctl", 32'(ctl0), 32'b1110_1000); tick();
        idle(); rs_addr = {5'd7, 5'd3}; rs_used = 2'b11; wb_rd = 7; wb_rw = 1;
        eval_cycle();
        chk("lu_wb_fwd", 32'(fwd0[3:2]), 32'b10);
        chk("lu_release", 32'(ctl0[7]), 0);
        chk("lu_stat", 32'(stat0), 1);
        tick();

        // Branch during a load-use cycle, flush on release
        do_reset();
        rs_addr = {5'd7, 5'd3}; rs_used = 2'b11; mem_rd = 7; mem_rw = 1; mem_ld = 1; br = 1;
        eval_cycle(); chk("br_suppressed", 32'(ctl0[1:0]), 0); tick();
        mem_ld = 0; mem_rw = 0; mem_rd = 0; wb_rd = 7; wb_rw = 1;
        eval_cycle(); chk("br_flush", 32'(ctl0[1:0]), 32'b11); tick();
        br = 0;
        eval_cycle(); chk("br_once", 32'(ctl0[1:0]), 0); tick();

        // LOAD_LAT=3, independent EX instruction
        do_reset();
        rs_addr = {5'd2, 5'd1}; rs_used = 2'b11; mem_rd = 9; mem_rw = 1; mem_ld = 1;
        for (int c = 0; c < 3; c++) begin
            eval_cycle();
            chk($sformatf("l3_hold_mem%0d", c), 32'(ctl1[4]), (c < 2) ? 1 : 0);
            chk($sformatf("l3_bub_wb%0d", c), 32'(ctl1[2]), (c < 2) ? 1 : 0);
            tick();
        end
        idle();
        eval_cycle(); chk("l3_stat", 32'(stat1), 2); tick();

        // Reset in the middle of a LOAD_LAT=4 wait
        do_reset();
        rs_addr = {5'd2, 5'd1}; rs_used = 2'b11; mem_rd = 9; mem_rw = 1; mem_ld = 1;
        eval_cycle(); tick();
        eval_cycle(); tick();
        RST = 1;
        eval_cycle();
        chk("rst_ctl", 32'(ctl2), 0);
        chk("rst_fwd", 32'(fwd2), 0);
        tick();
        RST = 0;
        for (int c = 0; c < 4; c++) begin
            eval_cycle();
            chk($sformatf("l4_hold_mem%0d", c), 32'(ctl2[4]), (c < 3) ? 1 : 0);
            tick();
        end

        // External stall for five cycles; the 2-bit counter saturates
        do_reset();
        ext = 1;
        for (int c = 0; c < 5; c++) begin eval_cycle(); tick(); end
        ext = 0;
        eval_cycle();
        chk("ext_stat16", 32'(stat0), 5);
        chk("ext_stat2", 32'(stat2), 3);
        tick();

        // Randomized traffic; MEM contents tend to linger so waits complete
        for (int n = 0; n < 3000; n++) begin
            RST = ($urandom_range(0, 49) == 0);
            rs_addr = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
            rs_used = 2'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                mem_rd = 5'($urandom_range(0, 3));
                mem_ld = ($urandom_range(0, 2) == 0);
                mem_rw = mem_ld ? 1'b1 : 1'($urandom);
            end
            wb_rd = 5'($urandom_range(0, 3));
            wb_rw = 1'($urandom);
            br    = ($urandom_range(0, 3) == 0);
            ext   = ($urandom_range(0, 5) == 0);
            eval_cycle();
            tick();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
